ip_flit_receiver: RTL and testbench

- Receive-side IP endpoint attached to a switch's local port. It is the sink counterpart of the flit generator.
- Accepts flits over the wr/r ready handshake and reassembles packets by tail flag.
- Checks each flit's destination address and each packet's length, and exports received-packet/flit counters and error counters.
- The NoC testbench sums recv_packs across nodes for termination.

---
 rtl/ip_flit_receiver.sv | 136 +++++++++++++
 tb/tb_ip_flit_receiver.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ip_flit_receiver.sv
// Sink-side NoC endpoint: accepts flits over a valid/ready handshake, reassembles
// packets by tail flag, and keeps saturating receive and error counters.
module ip_flit_receiver #(
  parameter int DATA_SIZE    = 8,
  parameter int ADDR_SIZE    = 4,
  parameter int ADDR         = 0,
  parameter int MAX_PACK_LEN = 4,
  parameter int FLIT_DELAY   = 0,
  localparam int FLIT_SIZE   = DATA_SIZE + ADDR_SIZE + 1
) (
  input  logic                 clk,
  input  logic                 a_rst,
  input  logic [FLIT_SIZE-1:0] data_i,
  input  logic                 wr_ready_in,
  output logic                 r_ready_out,
  output logic [31:0]          recv_packs,
  output logic [31:0]          recv_flits,
  output logic [15:0]          addr_errs,
  output logic [15:0]          len_errs,
  output logic                 pack_done,
  output logic [15:0]          pack_len,
  output logic [DATA_SIZE-1:0] last_data
);

  localparam int SCW = (FLIT_DELAY > 1) ? $clog2(FLIT_DELAY) : 1;
  localparam logic [SCW-1:0]       STALL_LOAD = SCW'((FLIT_DELAY > 0) ? FLIT_DELAY - 1 : 0);
  localparam logic [15:0]          MAX_LEN    = 16'(MAX_PACK_LEN);
  localparam logic [ADDR_SIZE-1:0] MY_ADDR    = ADDR_SIZE'(ADDR);

  typedef enum logic [1:0] {
    S_IDLE,
    S_BODY,
    S_STALL
  } state_t;

  state_t         state_q, state_d;
  state_t         ret_q, ret_d;
  logic [SCW-1:0] stall_q, stall_d;
  logic [15:0]    flit_cnt_q, flit_cnt_d;
  logic           ready_d;
  logic           complete;

  logic                 fire;
  logic                 tail;
  logic [ADDR_SIZE-1:0] dest;
  logic [DATA_SIZE-1:0] payload;
  logic [15:0]          cur_len;

  function automatic logic [31:0] sat32(input logic [31:0] v);
    return (v == '1) ? v : v + 32'd1;
  endfunction

  function automatic logic [15:0] sat16(input logic [15:0] v);
    return (v == '1) ? v : v + 16'd1;
  endfunction

  assign fire    = wr_ready_in && r_ready_out;
  assign tail    = data_i[FLIT_SIZE-1];
  assign dest    = data_i[FLIT_SIZE-2 -: ADDR_SIZE];
  assign payload = data_i[DATA_SIZE-1:0];
  // flit_cnt_q is zero between packets, so this is the length including the current flit.
  assign cur_len = sat16(flit_cnt_q);

  // NOTE: every signal gets a default before the case so no path leaves one unassigned (no latches).
  always_comb begin
    state_d    = state_q;
    ret_d      = ret_q;
    stall_d    = stall_q;
    flit_cnt_d = flit_cnt_q;
    complete   = 1'b0;
    unique case (state_q)
      S_IDLE, S_BODY: begin
        if (fire) begin
          state_t after;
          if (tail) begin
            complete   = 1'b1;
            flit_cnt_d = '0;
            after      = S_IDLE;
          end else begin
            flit_cnt_d = cur_len;
            after      = S_BODY;
          end
          if (FLIT_DELAY > 0) begin
            ret_d   = after;
            stall_d = STALL_LOAD;
            state_d = S_STALL;
          end else begin
            state_d = after;
          end
        end
      end
      S_STALL: begin
        if (stall_q == '0) state_d = ret_q;
        else               stall_d = stall_q - 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
    ready_d = (state_d != S_STALL);
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!a_rst) begin
      state_q     <= S_IDLE;
      ret_q       <= S_IDLE;
      stall_q     <= '0;
      flit_cnt_q  <= '0;
      r_ready_out <= 1'b0;
      recv_packs  <= '0;
      recv_flits  <= '0;
      addr_errs   <= '0;
      len_errs    <= '0;
      pack_done   <= 1'b0;
      pack_len    <= '0;
      last_data   <= '0;
    end else begin
      state_q     <= state_d;
      ret_q       <= ret_d;
      stall_q     <= stall_d;
      flit_cnt_q  <= flit_cnt_d;
      r_ready_out <= ready_d;
      pack_done   <= complete;
      if (fire) begin
        recv_flits <= sat32(recv_flits);
        last_data  <= payload;
        if (dest != MY_ADDR) addr_errs <= sat16(addr_errs);
      end
      if (complete) begin
        recv_packs <= sat32(recv_packs);
        pack_len   <= cur_len;
        if (cur_len > MAX_LEN) len_errs <= sat16(len_errs);
      end
    end
  end

endmodule

// File: tb/tb_ip_flit_receiver.sv
// Self-checking bench for ip_flit_receiver: vector table plus hand sequences, with a
// packet-length scoreboard popped on every pack_done pulse.
module tb_ip_flit_receiver;

  localparam int DW = 8;
  localparam int AW = 4;
  localparam int FW = DW + AW + 1;

  typedef struct {
    logic          tail;
    logic [AW-1:0] dest;
    logic [DW-1:0] payload;
    int unsigned   flits;
    int unsigned   packs;
    int unsigned   aerr;
    int unsigned   lerr;
  } vec_t;

  logic clk = 1'b0;
  logic a_rst = 1'b0;

  // Main instance, no stall.
  logic [FW-1:0] data_i;
  logic          wr_ready_in;
  logic          r_ready_out;
  logic [31:0]   recv_packs, recv_flits;
  logic [15:0]   addr_errs, len_errs, pack_len;
  logic          pack_done;
  logic [DW-1:0] last_data;

  // Second instance with a two-cycle stall after each flit.
  logic [FW-1:0] d_data;
  logic          d_wr;
  logic          d_ready;
  logic [31:0]   d_packs, d_flits;
  logic [15:0]   d_aerr, d_lerr, d_plen;
  logic          d_done;
  logic [DW-1:0] d_last;

  int n_cmp    = 0;
  int n_err    = 0;
  int open_len = 0;
  int run_len  = 0;
  int run_max  = 0;
  int exp_len_q[$];

  ip_flit_receiver #(
    .DATA_SIZE(DW), .ADDR_SIZE(AW), .ADDR(3), .MAX_PACK_LEN(4), .FLIT_DELAY(0)
  ) dut (
    .clk(clk), .a_rst(a_rst), .data_i(data_i), .wr_ready_in(wr_ready_in),
    .r_ready_out(r_ready_out), .recv_packs(recv_packs), .recv_flits(recv_flits),
    .addr_errs(addr_errs), .len_errs(len_errs), .pack_done(pack_done),
    .pack_len(pack_len), .last_data(last_data)
  );

  ip_flit_receiver #(
    .DATA_SIZE(DW), .ADDR_SIZE(AW), .ADDR(3), .MAX_PACK_LEN(4), .FLIT_DELAY(2)
  ) dut_d (
    .clk(clk), .a_rst(a_rst), .data_i(d_data), .wr_ready_in(d_wr),
    .r_ready_out(d_ready), .recv_packs(d_packs), .recv_flits(d_flits),
    .addr_errs(d_aerr), .len_errs(d_lerr), .pack_done(d_done),
    .pack_len(d_plen), .last_data(d_last)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Drives one flit at a falling edge; returns at the next falling edge after it is taken.
  task automatic send(input logic t, input logic [AW-1:0] d, input logic [DW-1:0] p);
    data_i      = {t, d, p};
    wr_ready_in = 1'b1;
    check("ready_before_xfer", r_ready_out, 1);
    if (t) begin
      exp_len_q.push_back(open_len + 1);
      open_len = 0;
    end else begin
      open_len++;
    end
    @(negedge clk);
    wr_ready_in = 1'b0;
  endtask

  // Holds reset for three edges with the sender valid, checking that nothing gets through.
  task automatic do_reset();
    @(negedge clk);
    a_rst       = 1'b0;
    wr_ready_in = 1'b1;
    data_i      = {1'b1, 4'd3, 8'hEE};
    repeat (3) begin
      @(negedge clk);
      check("rst_ready",      r_ready_out, 0);
      check("rst_recv_flits", recv_flits,  0);
      check("rst_recv_packs", recv_packs,  0);
      check("rst_addr_errs",  addr_errs,   0);
      check("rst_len_errs",   len_errs,    0);
      check("rst_pack_len",   pack_len,    0);
      check("rst_last_data",  last_data,   0);
      check("rst_pack_done",  pack_done,   0);
    end
    a_rst       = 1'b1;
    wr_ready_in = 1'b0;
    open_len    = 0;
    @(negedge clk);
    check("ready_after_rst", r_ready_out, 1);
    check("flits_after_rst", recv_flits,  0);
  endtask

  // Scoreboard consumer: each pack_done pulse must match the oldest expected length.
  initial begin
    forever begin
      @(negedge clk);
      if (pack_done === 1'b1) begin
        run_len++;
        if (run_len > run_max) run_max = run_len;
        if (exp_len_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL pack_done_unexpected: got pulse, expected none at %0t", $time);
        end else begin
          check("pack_len_sb", pack_len, exp_len_q.pop_front());
        end
      end else begin
        run_len = 0;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t  vecs[9];
    logic  [FW-1:0] flits3[3];
    bit    pat[7];
    logic  acc;
    int    idx;

    vecs[0] = '{1'b0, 4'd3, 8'h11, 1, 0, 0, 0};
    vecs[1] = '{1'b0, 4'd3, 8'h22, 2, 0, 0, 0};
    vecs[2] = '{1'b1, 4'd3, 8'h33, 3, 1, 0, 0};
    vecs[3] = '{1'b0, 4'd3, 8'h41, 4, 1, 0, 0};
    vecs[4] = '{1'b0, 4'd3, 8'h42, 5, 1, 0, 0};
    vecs[5] = '{1'b0, 4'd3, 8'h43, 6, 1, 0, 0};
    vecs[6] = '{1'b0, 4'd3, 8'h44, 7, 1, 0, 0};
    vecs[7] = '{1'b1, 4'd3, 8'h45, 8, 2, 0, 1};
    vecs[8] = '{1'b1, 4'd5, 8'h56, 9, 3, 1, 1};

    flits3[0] = {1'b1, 4'd3, 8'hA1};
    flits3[1] = {1'b0, 4'd3, 8'hA2};
    flits3[2] = {1'b1, 4'd3, 8'hA3};
    pat       = '{1, 0, 0, 1, 0, 0, 1};

    wr_ready_in = 1'b0;
    data_i      = '0;
    d_wr        = 1'b0;
    d_data      = '0;

    do_reset();

    // Stalling instance: 1-flit packet then 2-flit packet, sender always valid.
    idx    = 0;
    d_data = flits3[0];
    d_wr   = 1'b1;
    for (int k = 0; k < 7; k++) begin
      check("stall_ready_pattern", d_ready, pat[k]);
      acc = d_ready;
      @(posedge clk);
      #1;
      if (acc) begin
        idx++;
        if (idx < 3) d_data = flits3[idx];
        else         d_wr   = 1'b0;
      end
      @(negedge clk);
    end
    check("stall_recv_packs", d_packs, 2);
    check("stall_recv_flits", d_flits, 3);
    check("stall_last_data",  d_last,  8'hA3);
    check("stall_pack_len",   d_plen,  2);
    check("stall_addr_errs",  d_aerr,  0);

    // Vector table: 3-flit packet, 5-flit overlong packet, 1-flit misaddressed packet.
    foreach (vecs[i]) begin
      send(vecs[i].tail, vecs[i].dest, vecs[i].payload);
      check("vec_recv_flits", recv_flits, vecs[i].flits);
      check("vec_recv_packs", recv_packs, vecs[i].packs);
      check("vec_last_data",  last_data,  vecs[i].payload);
      check("vec_addr_errs",  addr_errs,  vecs[i].aerr);
      check("vec_len_errs",   len_errs,   vecs[i].lerr);
    end
    @(negedge clk);
    check("pack_len_held",  pack_len,  1);
    check("pack_done_low",  pack_done, 0);

    // Reset with a packet open discards it entirely.
    send(1'b0, 4'd3, 8'h61);
    send(1'b0, 4'd3, 8'h62);
    do_reset();
    send(1'b1, 4'd3, 8'h71);
    check("post_rst_recv_packs", recv_packs, 1);
    check("post_rst_recv_flits", recv_flits, 1);
    check("post_rst_pack_len",   pack_len,   1);
    check("post_rst_len_errs",   len_errs,   0);

    // 1000 back-to-back single-flit packets.
    do_reset();
    run_max = 0;
    repeat (1000) send(1'b1, 4'd3, 8'h5A);
    @(negedge clk);
    check("b2b_pack_done_run", run_max,    1000);
    check("b2b_recv_packs",    recv_packs, 1000);
    check("b2b_recv_flits",    recv_flits, 1000);

    // Saturation: preload counters one below maximum, then overflow them.
    force dut.recv_packs = 32'hFFFF_FFFE;
    force dut.addr_errs  = 16'hFFFE;
    send(1'b1, 4'd5, 8'h77);
    release dut.recv_packs;
    release dut.addr_errs;
    send(1'b1, 4'd5, 8'h78);
    send(1'b1, 4'd5, 8'h79);
    check("sat_recv_packs", recv_packs, 32'hFFFF_FFFF);
    check("sat_addr_errs",  addr_errs,  16'hFFFF);
    check("sat_last_data",  last_data,  8'h79);

    @(negedge clk);
    check("scoreboard_empty", exp_len_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
